// File: rtl/calc_pkg.sv
// Shared definitions for the calculator ALU path: opcodes, arbiter states, default width.
package calc_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 16;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StReturn
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and ALU handshake bundle of the ALU arbiter; names are from the arbiter's viewpoint.
interface alu_arbiter_if #(
  parameter int unsigned DATA_WIDTH = calc_pkg::DATA_WIDTH_DEFAULT
) ();

  logic [DATA_WIDTH-1:0] i_r0_a, i_r0_b, o_r0_result;
  logic [1:0]            i_r0_op;
  logic                  i_r0_signed, i_r0_valid, o_r0_ready;
  logic                  o_r0_error, o_r0_result_valid, i_r0_result_ready;

  logic [DATA_WIDTH-1:0] i_r1_a, i_r1_b, o_r1_result;
  logic [1:0]            i_r1_op;
  logic                  i_r1_signed, i_r1_valid, o_r1_ready;
  logic                  o_r1_error, o_r1_result_valid, i_r1_result_ready;

  logic [DATA_WIDTH-1:0] o_alu_input_a, o_alu_input_b, i_alu_result;
  logic [1:0]            o_alu_input_op;
  logic                  o_alu_input_signed, o_alu_input_valid, i_alu_input_ready;
  logic                  i_alu_error, i_alu_result_valid, o_alu_result_ready;

  // Arbiter side.
  modport slave (
    input  i_r0_a, i_r0_b, i_r0_op, i_r0_signed, i_r0_valid, i_r0_result_ready,
    input  i_r1_a, i_r1_b, i_r1_op, i_r1_signed, i_r1_valid, i_r1_result_ready,
    input  i_alu_input_ready, i_alu_result, i_alu_error, i_alu_result_valid,
    output o_r0_ready, o_r0_result, o_r0_error, o_r0_result_valid,
    output o_r1_ready, o_r1_result, o_r1_error, o_r1_result_valid,
    output o_alu_input_a, o_alu_input_b, o_alu_input_op, o_alu_input_signed,
    output o_alu_input_valid, o_alu_result_ready
  );

  // Requesters plus ALU side.
  modport master (
    output i_r0_a, i_r0_b, i_r0_op, i_r0_signed, i_r0_valid, i_r0_result_ready,
    output i_r1_a, i_r1_b, i_r1_op, i_r1_signed, i_r1_valid, i_r1_result_ready,
    output i_alu_input_ready, i_alu_result, i_alu_error, i_alu_result_valid,
    input  o_r0_ready, o_r0_result, o_r0_error, o_r0_result_valid,
    input  o_r1_ready, o_r1_result, o_r1_error, o_r1_result_valid,
    input  o_alu_input_a, o_alu_input_b, o_alu_input_op, o_alu_input_signed,
    input  o_alu_input_valid, o_alu_result_ready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant; on contention the client not granted last wins.
module rr_arbiter2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic any_o
);

  always_comb begin
    any_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = valid1_i;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters with round-robin fairness and a watchdog.
module alu_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic         o_busy,
  output logic         o_owner,
  output logic         o_timeout
);

  localparam int unsigned TimerWidth = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerWidth-1:0] TimerLast =
      TimerWidth'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit WatchdogEn = (TIMEOUT_CYCLES != 0);

  arb_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0]            op_q, op_d;
  logic                  signed_q, signed_d, error_q, error_d;
  logic                  owner_q, owner_d, last_grant_q, last_grant_d, drain_q, drain_d;
  logic [TimerWidth-1:0] timer_q, timer_d;

  logic grant, req_any, issue_hs, expire, owner_res_ready;

  rr_arbiter2 u_rr (
    .valid0_i    (bus.i_r0_valid),
    .valid1_i    (bus.i_r1_valid),
    .last_grant_i(last_grant_q),
    .grant_o     (grant),
    .any_o       (req_any)
  );

  assign issue_hs = (state_q == StIssue) && !drain_q && bus.i_alu_input_ready;
  // A result on the expiry cycle wins over the watchdog.
  assign expire   = WatchdogEn && (state_q == StWait) && !bus.i_alu_result_valid &&
                    (timer_q == TimerLast);
  assign owner_res_ready = owner_q ? bus.i_r1_result_ready : bus.i_r0_result_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      signed_q     <= 1'b0;
      result_q     <= '0;
      error_q      <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      drain_q      <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      signed_q     <= signed_d;
      result_q     <= result_d;
      error_q      <= error_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      drain_q      <= drain_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (req_any) state_d = StIssue;
      StIssue:  if (issue_hs) state_d = StWait;
      StWait:   if (bus.i_alu_result_valid || expire) state_d = StReturn;
      StReturn: if (owner_res_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    signed_d     = signed_q;
    result_d     = result_q;
    error_d      = error_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    drain_d      = drain_q;
    timer_d      = timer_q;

    if ((state_q == StIdle) && req_any) begin
      a_d      = grant ? bus.i_r1_a : bus.i_r0_a;
      b_d      = grant ? bus.i_r1_b : bus.i_r0_b;
      op_d     = grant ? bus.i_r1_op : bus.i_r0_op;
      signed_d = grant ? bus.i_r1_signed : bus.i_r0_signed;
      owner_d  = grant;
    end

    if (issue_hs) timer_d = '0;

    if (state_q == StWait) begin
      if (bus.i_alu_result_valid) begin
        result_d = bus.i_alu_result;
        error_d  = bus.i_alu_error;
      end else if (expire) begin
        // The abandoned op may still answer later; drain swallows that stale result.
        result_d = '0;
        error_d  = 1'b1;
        drain_d  = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else if (drain_q && bus.i_alu_result_valid) begin
      drain_d = 1'b0;
    end

    if ((state_q == StReturn) && owner_res_ready) last_grant_d = owner_q;
  end

  always_comb begin
    bus.o_r0_ready         = (state_q == StIdle) && !grant && bus.i_r0_valid;
    bus.o_r1_ready         = (state_q == StIdle) && grant && bus.i_r1_valid;
    bus.o_r0_result        = result_q;
    bus.o_r1_result        = result_q;
    bus.o_r0_error         = error_q;
    bus.o_r1_error         = error_q;
    bus.o_r0_result_valid  = (state_q == StReturn) && !owner_q;
    bus.o_r1_result_valid  = (state_q == StReturn) && owner_q;
    bus.o_alu_input_a      = a_q;
    bus.o_alu_input_b      = b_q;
    bus.o_alu_input_op     = op_q;
    bus.o_alu_input_signed = signed_q;
    bus.o_alu_input_valid  = (state_q == StIssue) && !drain_q;
    bus.o_alu_result_ready = (state_q == StWait) || drain_q;
    o_busy                 = (state_q != StIdle);
    o_owner                = owner_q;
    o_timeout              = expire;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single-requester ops plus contention, watchdog and reset.
module tb_alu_arbiter;
  import calc_pkg::*;

  typedef struct {
    logic        req;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        sgn;
    int          delay;
    logic [15:0] res;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, owner, timeout;
  int   checks = 0;
  int   errors = 0;

  vec_t        vecs[6];
  logic [15:0] alt_a[4], alt_b[4], alt_res[4];
  logic [1:0]  alt_op[4];

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(16)) bus ();

  alu_arbiter #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .o_busy   (busy),
    .o_owner  (owner),
    .o_timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rv(input logic r);
    return r ? bus.o_r1_result_valid : bus.o_r0_result_valid;
  endfunction

  task automatic drive_req(input logic r, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] op, input logic sgn);
    if (!r) begin
      bus.i_r0_a = a; bus.i_r0_b = b; bus.i_r0_op = op; bus.i_r0_signed = sgn;
      bus.i_r0_valid = 1'b1;
    end else begin
      bus.i_r1_a = a; bus.i_r1_b = b; bus.i_r1_op = op; bus.i_r1_signed = sgn;
      bus.i_r1_valid = 1'b1;
    end
  endtask

  // Waits (bounded) for a grant, checks who got it, completes the handshake.
  task automatic wait_accept(input logic exp_req);
    int n = 0;
    #1;
    while (!(bus.o_r0_ready || bus.o_r1_ready) && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk1("accept_r0_ready", bus.o_r0_ready, !exp_req);
    chk1("accept_r1_ready", bus.o_r1_ready, exp_req);
    tick();
    if (!exp_req) bus.i_r0_valid = 1'b0;
    else bus.i_r1_valid = 1'b0;
  endtask

  task automatic serve_alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                           input logic sgn, input int delay, input logic [15:0] res,
                           input logic err);
    #1;
    chk1("issue_valid", bus.o_alu_input_valid, 1'b1);
    chk16("issue_a", bus.o_alu_input_a, a);
    chk16("issue_b", bus.o_alu_input_b, b);
    chk16("issue_op", {14'd0, bus.o_alu_input_op}, {14'd0, op});
    chk1("issue_signed", bus.o_alu_input_signed, sgn);
    bus.i_alu_input_ready = 1'b1;
    tick();
    bus.i_alu_input_ready = 1'b0;
    for (int d = 0; d < delay; d++) tick();
    bus.i_alu_result = res;
    bus.i_alu_error = err;
    bus.i_alu_result_valid = 1'b1;
    #1;
    chk1("wait_result_ready", bus.o_alu_result_ready, 1'b1);
    chk1("wait_no_timeout", timeout, 1'b0);
    tick();
    bus.i_alu_result_valid = 1'b0;
    bus.i_alu_error = 1'b0;
  endtask

  task automatic collect(input logic r, input logic [15:0] res, input logic err);
    #1;
    chk1("ret_valid", rv(r), 1'b1);
    chk1("ret_other_valid", rv(!r), 1'b0);
    chk16("ret_result", r ? bus.o_r1_result : bus.o_r0_result, res);
    chk1("ret_error", r ? bus.o_r1_error : bus.o_r0_error, err);
    chk1("ret_owner", owner, r);
    // Non-owner ready must not complete the return.
    if (!r) bus.i_r1_result_ready = 1'b1;
    else bus.i_r0_result_ready = 1'b1;
    tick();
    #1;
    chk1("hold_valid", rv(r), 1'b1);
    chk16("hold_result", r ? bus.o_r1_result : bus.o_r0_result, res);
    bus.i_r0_result_ready = !r;
    bus.i_r1_result_ready = r;
    tick();
    bus.i_r0_result_ready = 1'b0;
    bus.i_r1_result_ready = 1'b0;
    #1;
    chk1("ret_idle", busy, 1'b0);
    chk1("ret_valid_low", rv(r), 1'b0);
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_owner"}, owner, 1'b0);
    chk1({tag, "_timeout"}, timeout, 1'b0);
    chk1({tag, "_rv0"}, bus.o_r0_result_valid, 1'b0);
    chk1({tag, "_rv1"}, bus.o_r1_result_valid, 1'b0);
    chk16({tag, "_res0"}, bus.o_r0_result, 16'h0);
    chk16({tag, "_res1"}, bus.o_r1_result, 16'h0);
    chk1({tag, "_err1"}, bus.o_r1_error, 1'b0);
    chk1({tag, "_alu_valid"}, bus.o_alu_input_valid, 1'b0);
    chk16({tag, "_alu_a"}, bus.o_alu_input_a, 16'h0);
    chk1({tag, "_alu_res_ready"}, bus.o_alu_result_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{req: 1'b0, a: 16'd7, b: 16'd5, op: OP_ADD, sgn: 1'b0, delay: 3,
                res: 16'd12, err: 1'b0};
    vecs[1] = '{req: 1'b1, a: 16'd5, b: 16'd0, op: OP_DIV, sgn: 1'b0, delay: 2,
                res: 16'd0, err: 1'b1};
    vecs[2] = '{req: 1'b1, a: 16'd8, b: 16'd2, op: OP_SUB, sgn: 1'b1, delay: 0,
                res: 16'd6, err: 1'b0};
    vecs[3] = '{req: 1'b0, a: 16'd9, b: 16'd3, op: OP_MUL, sgn: 1'b0, delay: 1,
                res: 16'd27, err: 1'b0};
    vecs[4] = '{req: 1'b0, a: 16'hFFFF, b: 16'h0001, op: OP_ADD, sgn: 1'b0, delay: 0,
                res: 16'h0000, err: 1'b0};
    // Result on the last watchdog cycle: still a normal completion.
    vecs[5] = '{req: 1'b1, a: 16'h1200, b: 16'h0034, op: OP_ADD, sgn: 1'b0, delay: 7,
                res: 16'h1234, err: 1'b0};

    alt_a   = '{16'd9, 16'd8, 16'd4, 16'd3};
    alt_b   = '{16'd3, 16'd2, 16'd4, 16'd1};
    alt_op  = '{OP_MUL, OP_SUB, OP_ADD, OP_SUB};
    alt_res = '{16'd27, 16'd6, 16'd8, 16'd2};

    bus.i_r0_a = '0; bus.i_r0_b = '0; bus.i_r0_op = '0; bus.i_r0_signed = 1'b0;
    bus.i_r0_valid = 1'b0; bus.i_r0_result_ready = 1'b0;
    bus.i_r1_a = '0; bus.i_r1_b = '0; bus.i_r1_op = '0; bus.i_r1_signed = 1'b0;
    bus.i_r1_valid = 1'b0; bus.i_r1_result_ready = 1'b0;
    bus.i_alu_input_ready = 1'b0; bus.i_alu_result = '0; bus.i_alu_error = 1'b0;
    bus.i_alu_result_valid = 1'b0;

    repeat (3) tick();
    chk_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sgn);
      wait_accept(vecs[i].req);
      serve_alu(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sgn, vecs[i].delay,
                vecs[i].res, vecs[i].err);
      collect(vecs[i].req, vecs[i].res, vecs[i].err);
    end

    // Contention from reset: strict alternation 0,1,0,1 with both kept busy.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_req(1'b0, alt_a[0], alt_b[0], alt_op[0], 1'b0);
    drive_req(1'b1, alt_a[1], alt_b[1], alt_op[1], 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_accept(k[0]);
      if (k + 2 < 4) drive_req(k[0], alt_a[k+2], alt_b[k+2], alt_op[k+2], 1'b0);
      serve_alu(alt_a[k], alt_b[k], alt_op[k], 1'b0, 1, alt_res[k], 1'b0);
      collect(k[0], alt_res[k], 1'b0);
    end

    // Watchdog: silent ALU expires on the 8th WAIT cycle.
    drive_req(1'b0, 16'h0101, 16'h0202, OP_ADD, 1'b0);
    wait_accept(1'b0);
    #1;
    chk1("to_issue_valid", bus.o_alu_input_valid, 1'b1);
    bus.i_alu_input_ready = 1'b1;
    tick();
    bus.i_alu_input_ready = 1'b0;
    for (int d = 0; d < 7; d++) begin
      #1;
      chk1("to_quiet", timeout, 1'b0);
      tick();
    end
    #1;
    chk1("to_pulse", timeout, 1'b1);
    tick();
    chk1("to_pulse_once", timeout, 1'b0);
    collect(1'b0, 16'h0000, 1'b1);

    // Next request stalls until the stale result is drained.
    drive_req(1'b1, 16'h0030, 16'h0004, OP_MUL, 1'b0);
    wait_accept(1'b1);
    bus.i_alu_input_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      #1;
      chk1("drain_stall_valid", bus.o_alu_input_valid, 1'b0);
      chk1("drain_result_ready", bus.o_alu_result_ready, 1'b1);
      chk1("drain_busy", busy, 1'b1);
      tick();
    end
    bus.i_alu_result = 16'hDEAD;
    bus.i_alu_error = 1'b1;
    bus.i_alu_result_valid = 1'b1;
    #1;
    chk1("drain_discard_stall", bus.o_alu_input_valid, 1'b0);
    tick();
    bus.i_alu_result_valid = 1'b0;
    bus.i_alu_error = 1'b0;
    bus.i_alu_input_ready = 1'b0;
    serve_alu(16'h0030, 16'h0004, OP_MUL, 1'b0, 1, 16'h00C0, 1'b0);
    collect(1'b1, 16'h00C0, 1'b0);

    // Reset in WAIT after r0 was served last; r0 must still win afterwards.
    drive_req(1'b0, 16'd1, 16'd1, OP_ADD, 1'b0);
    wait_accept(1'b0);
    serve_alu(16'd1, 16'd1, OP_ADD, 1'b0, 0, 16'd2, 1'b0);
    collect(1'b0, 16'd2, 1'b0);
    drive_req(1'b1, 16'd6, 16'd2, OP_DIV, 1'b0);
    wait_accept(1'b1);
    bus.i_alu_input_ready = 1'b1;
    tick();
    bus.i_alu_input_ready = 1'b0;
    #1;
    chk1("rst_wait_pre_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_wait");
    drive_req(1'b0, 16'd3, 16'd4, OP_MUL, 1'b0);
    drive_req(1'b1, 16'h55A0, 16'h000A, OP_ADD, 1'b0);
    wait_accept(1'b0);
    serve_alu(16'd3, 16'd4, OP_MUL, 1'b0, 0, 16'd12, 1'b0);
    collect(1'b0, 16'd12, 1'b0);

    // Reset in RETURN while r1 owns the result.
    wait_accept(1'b1);
    serve_alu(16'h55A0, 16'h000A, OP_ADD, 1'b0, 0, 16'h55AA, 1'b0);
    #1;
    chk1("rst_ret_pre_valid", bus.o_r1_result_valid, 1'b1);
    chk1("rst_ret_pre_owner", owner, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_return");
    drive_req(1'b0, 16'd2, 16'd2, OP_ADD, 1'b0);
    drive_req(1'b1, 16'd2, 16'd2, OP_SUB, 1'b0);
    wait_accept(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
